// File: rtl/activation_pipe.sv
// activation_pipe: multi-lane, two-stage pipelined activation unit.
// Each beat carries LANES signed Q(INT_BITS.FRAC_BITS) words and one mode:
// sigmoid (piecewise power-of-two approximation), tanh (built on the sigmoid
// of 2t), ReLU or identity. Valid/ready on both sides; a single advance enable
// stalls the whole pipe when the output is held.
module activation_pipe #(
    parameter int INT_BITS  = 7,
    parameter int FRAC_BITS = 8,
    parameter int LANES     = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [1:0]                              in_mode,
    input  logic [LANES*(1+INT_BITS+FRAC_BITS)-1:0] in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [LANES*(1+INT_BITS+FRAC_BITS)-1:0] out_data,
    output logic [LANES-1:0]                        out_sat
);

    localparam int W = 1 + INT_BITS + FRAC_BITS;

    localparam logic [1:0] MODE_SIG  = 2'd0;
    localparam logic [1:0] MODE_TANH = 2'd1;
    localparam logic [1:0] MODE_RELU = 2'd2;
    localparam logic [1:0] MODE_ID   = 2'd3;

    localparam logic signed [W-1:0]   MAX_W   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   MIN_W   = {1'b1, {(W-1){1'b0}}};
    localparam logic [FRAC_BITS:0]    ONE_F   = {1'b1, {FRAC_BITS{1'b0}}};
    localparam logic [FRAC_BITS:0]    HALF_F  = {2'b01, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [W-1:0]   ONE_W   = {{INT_BITS{1'b0}}, ONE_F};
    localparam logic [INT_BITS-1:0]   N_LIMIT = INT_BITS'(FRAC_BITS);

    // Doubling overflows exactly when the two top bits differ.
    function automatic logic dbl_ovf(input logic signed [W-1:0] x);
        return x[W-1] ^ x[W-2];
    endfunction

    // 2x with saturation to the W-bit signed range.
    function automatic logic signed [W-1:0] sat_dbl(input logic signed [W-1:0] x);
        if (dbl_ovf(x))
            return x[W-1] ? MIN_W : MAX_W;
        return {x[W-2:0], 1'b0};
    endfunction

    // Magnitude; the most negative code has no positive twin, so it clamps to max.
    function automatic logic [W-2:0] abs_sat(input logic signed [W-1:0] x);
        logic signed [W-1:0] neg;
        neg = -x;
        if (x == MIN_W)
            return {(W-1){1'b1}};
        return x[W-1] ? neg[W-2:0] : x[W-2:0];
    endfunction

    // Sigmoid from |t| split into integer n and fraction f:
    // s = (0.5 - f/4) >> n, result s for negative t and 1 - s otherwise.
    function automatic logic signed [W-1:0] sigmoid_q(input logic [INT_BITS-1:0]  n,
                                                      input logic [FRAC_BITS-1:0] f,
                                                      input logic                 neg);
        logic [FRAC_BITS:0] m;
        logic [FRAC_BITS:0] s;
        logic [FRAC_BITS:0] y;
        m = HALF_F - {3'b000, f[FRAC_BITS-1:2]};
        s = (n > N_LIMIT) ? '0 : (m >> n);
        y = neg ? s : (ONE_F - s);
        return {{INT_BITS{1'b0}}, y};
    endfunction

    // tanh(t) = 2*sigmoid(2t) - 1; the operand was already doubled in stage 1.
    function automatic logic signed [W-1:0] tanh_q(input logic [INT_BITS-1:0]  n,
                                                   input logic [FRAC_BITS-1:0] f,
                                                   input logic                 neg);
        logic signed [W-1:0] sg;
        sg = sigmoid_q(n, f, neg);
        return (sg <<< 1) - ONE_W;
    endfunction

    function automatic logic signed [W-1:0] relu_q(input logic signed [W-1:0] x);
        return x[W-1] ? '0 : x;
    endfunction

    logic                   w_en;

    logic [W-2:0]           w_abs_s0 [LANES];
    logic signed [W-1:0]    w_x_s0   [LANES];
    logic [LANES-1:0]       w_neg_s0;
    logic [LANES-1:0]       w_sat_s0;

    logic                   r_vld_p1;
    logic [1:0]             r_mode_p1;
    logic [W-2:0]           r_abs_p1 [LANES];
    logic signed [W-1:0]    r_x_p1   [LANES];
    logic [LANES-1:0]       r_neg_p1;
    logic [LANES-1:0]       r_sat_p1;

    logic [LANES*W-1:0]     w_res_s1;

    logic                   r_vld_p2;
    logic [LANES*W-1:0]     r_data_p2;
    logic [LANES-1:0]       r_sat_p2;

    // The whole pipe moves whenever the output slot is empty or being drained.
    assign w_en      = !r_vld_p2 || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_sat   = r_sat_p2;

    // ---- stage 0 -> 1: operand prep (double for tanh), magnitude, sign ----
    // Per-lane operand preparation for the incoming beat.
    always_comb begin
        logic signed [W-1:0] x;
        logic signed [W-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            x           = in_data[i*W +: W];
            v           = (in_mode == MODE_TANH) ? sat_dbl(x) : x;
            w_x_s0[i]   = x;
            w_abs_s0[i] = abs_sat(v);
            w_neg_s0[i] = v[W-1];
            w_sat_s0[i] = (in_mode == MODE_TANH) && dbl_ovf(x);
        end
    end

    // Stage-1 valid: cleared by reset, otherwise follows the input when the pipe advances.
    always_ff @(posedge clk) begin
        if (rst)
            r_vld_p1 <= 1'b0;
        else if (w_en)
            r_vld_p1 <= in_valid;
    end

    // Stage-1 data; n and f are the integer and fraction fields of the stored magnitude.
    always_ff @(posedge clk) begin
        if (w_en && in_valid) begin
            r_mode_p1 <= in_mode;
            r_neg_p1  <= w_neg_s0;
            r_sat_p1  <= w_sat_s0;
            for (int i = 0; i < LANES; i++) begin
                r_abs_p1[i] <= w_abs_s0[i];
                r_x_p1[i]   <= w_x_s0[i];
            end
        end
    end

    // ---- stage 1 -> 2: activation result selection ----
    // Per-lane activation using the mode captured with this beat.
    always_comb begin
        logic [INT_BITS-1:0]  n;
        logic [FRAC_BITS-1:0] f;
        w_res_s1 = '0;
        for (int i = 0; i < LANES; i++) begin
            n = r_abs_p1[i][W-2:FRAC_BITS];
            f = r_abs_p1[i][FRAC_BITS-1:0];
            case (r_mode_p1)
                MODE_SIG:  w_res_s1[i*W +: W] = sigmoid_q(n, f, r_neg_p1[i]);
                MODE_TANH: w_res_s1[i*W +: W] = tanh_q(n, f, r_neg_p1[i]);
                MODE_RELU: w_res_s1[i*W +: W] = relu_q(r_x_p1[i]);
                MODE_ID:   w_res_s1[i*W +: W] = r_x_p1[i];
            endcase
        end
    end

    // Output register: reset clears valid and data; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_sat_p2  <= '0;
        end else if (w_en) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_res_s1;
                r_sat_p2  <= r_sat_p1;
            end
        end
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Bench for activation_pipe at W=16, FRAC_BITS=8, LANES=4.
// Directed beats plus a scoreboard of expected {sat, data} popped on each output handshake.
module tb_activation_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_sat;

    int checks = 0;
    int errors = 0;

    logic [67:0] sb[$];

    always #5 clk = ~clk;

    activation_pipe #(
        .INT_BITS (7),
        .FRAC_BITS(8),
        .LANES    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference sigmoid on plain integers (Q7.8 codes).
    function automatic int m_sig(input int t);
        int a, n, f, m, s;
        a = (t < 0) ? -t : t;
        if (a > 32767) a = 32767;
        n = a / 256;
        f = a % 256;
        m = 128 - f / 4;
        s = (n > 8) ? 0 : (m >> n);
        return (t < 0) ? s : 256 - s;
    endfunction

    function automatic logic [67:0] model(input logic [1:0] md, input logic [63:0] d);
        logic [63:0] y;
        logic [3:0]  sat;
        int t, u, r;
        y = '0;
        sat = '0;
        for (int i = 0; i < 4; i++) begin
            t = $signed(d[i*16 +: 16]);
            case (md)
                2'd0: r = m_sig(t);
                2'd1: begin
                    u = 2 * t;
                    if (u > 32767) begin u = 32767; sat[i] = 1'b1; end
                    if (u < -32768) begin u = -32768; sat[i] = 1'b1; end
                    r = 2 * m_sig(u) - 256;
                end
                2'd2: r = (t < 0) ? 0 : t;
                default: r = t;
            endcase
            y[i*16 +: 16] = 16'(r);
        end
        return {sat, y};
    endfunction

    // Drive one beat and wait (bounded) for its input handshake.
    task automatic send(input logic [1:0] m, input logic [63:0] d, input logic [67:0] e,
                        output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        while (!acc && waits < 200) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                acc = 1'b1;
            end else begin
                waits++;
            end
        end
        chk("send_accept", {67'd0, acc}, 68'd1);
        if (acc) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", {36'd0, 32'(sb.size())}, 68'd0);
    endtask

    // Output monitor: scoreboard compare, stall stability and ready relation.
    logic        stall_prev = 1'b0;
    logic [67:0] held = '0;
    always @(negedge clk) begin
        logic [67:0] e;
        if (!rst) begin
            chk("in_ready_rel", {67'd0, in_ready}, {67'd0, (!out_valid || out_ready)});
            if (stall_prev) begin
                chk("stall_hold", {out_sat, out_data}, held);
                chk("stall_valid", {67'd0, out_valid}, 68'd1);
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", {67'd0, (sb.size() != 0)}, 68'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat", {out_sat, out_data}, e);
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_sat, out_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        logic [63:0] d;
        rst = 1'b1;
        in_valid = 1'b0;
        in_mode = 2'd0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {67'd0, out_valid}, 68'd0);
        chk("rst_out_data", {4'd0, out_data}, 68'd0);
        chk("rst_out_sat", {64'd0, out_sat}, 68'd0);
        chk("rst_in_ready", {67'd0, in_ready}, 68'd1);
        repeat (2) @(posedge clk);
        #1;

        // 1: sigmoid and 2-cycle latency
        send(2'd0, 64'hFD80_0100_FF00_0000, {4'b0000, 64'h0018_00C0_0040_0080}, w);
        chk("lat_s1", {67'd0, out_valid}, 68'd0);
        @(posedge clk);
        #1;
        chk("lat_s2", {67'd0, out_valid}, 68'd1);
        drain();

        // 2: sigmoid extremes including the most negative code
        send(2'd0, 64'h0900_F700_7FFF_8000, {4'b0000, 64'h0100_0000_0100_0000}, w);
        // 3: tanh with doubling saturation on lanes 1 and 2
        send(2'd1, 64'h0080_BF00_4100_0000, {4'b0110, 64'h0080_FF00_0100_0000}, w);
        // same data as sigmoid: no saturation flag outside tanh
        send(2'd0, 64'h0080_BF00_4100_0000, {4'b0000, 64'h00A0_0000_0100_0080}, w);
        // 4: relu and identity
        send(2'd2, 64'h7FFF_8000_0123_FF00, {4'b0000, 64'h7FFF_0000_0123_0000}, w);
        send(2'd3, 64'h7FFF_8000_0123_FF00, {4'b0000, 64'h7FFF_8000_0123_FF00}, w);
        drain();

        // 5: 20 back-to-back beats, modes cycling, full throughput
        for (int i = 0; i < 20; i++) begin
            d = {$urandom, $urandom};
            send(2'(i % 4), d, model(2'(i % 4), d), w);
            chk("b2b_no_wait", {36'd0, 32'(w)}, 68'd0);
        end
        drain();

        // 6a: out_ready low for 5 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    d = {$urandom, $urandom};
                    send(2'((i + 1) % 4), d, model(2'((i + 1) % 4), d), w);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk("stall_in_ready", {67'd0, in_ready}, 68'd0);
                chk("stall_out_valid", {67'd0, out_valid}, 68'd1);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // 6b: reset with two beats in flight
        send(2'd0, 64'h0100_0100_0100_0100, {4'b0000, 64'h00C0_00C0_00C0_00C0}, w);
        send(2'd1, 64'h4100_4100_4100_4100, {4'b1111, 64'h0100_0100_0100_0100}, w);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("flush_out_valid", {67'd0, out_valid}, 68'd0);
        chk("flush_out_data", {4'd0, out_data}, 68'd0);
        chk("flush_out_sat", {64'd0, out_sat}, 68'd0);
        chk("flush_in_ready", {67'd0, in_ready}, 68'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("flush_no_stale", {67'd0, out_valid}, 68'd0);
        end

        // pipe still works after the flush
        send(2'd2, 64'h8001_0001_FFFF_7000, {4'b0000, 64'h0000_0001_0000_7000}, w);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
